// File: rtl/softmax_pkg.sv
// Shared definitions for the numerically stable softmax engine.
//   state_e  : top-level controller states (also visible on the debug port)
//   sat_sub  : signed subtraction clamped to a given two's-complement width
//   FIXED_PNT_DEF / ONE_FX / QW : default fixed-point scaling, 1.0 and the
//              quotient width that holds any result in [0, 1.0]
package softmax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MAX,
    EXP,
    DIV,
    DONE
  } state_e;

  localparam int FIXED_PNT_DEF = 8;
  localparam int ONE_FX        = 1 << FIXED_PNT_DEF;
  localparam int QW            = FIXED_PNT_DEF + 1;

  // a - b evaluated without wrap, then clamped to [-2^(width-1), 2^(width-1)-1].
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 width);
    longint diff;
    longint lo;
    longint hi;
    diff = longint'(a) - longint'(b);
    lo   = -(longint'(1) <<< (width - 1));
    hi   = (longint'(1) <<< (width - 1)) - 1;
    if (diff < lo) begin
      diff = lo;
    end else if (diff > hi) begin
      diff = hi;
    end
    return diff[31:0];
  endfunction

endpackage

// File: rtl/softmax_div_seq.sv
// Sequential restoring divider producing a QW-bit unsigned quotient.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle request, operands sampled in that cycle
//   dividend  : unsigned, must be < divisor << QW
//   divisor   : unsigned
//   done      : one-cycle pulse exactly QW cycles after start
//   quotient  : floor(dividend / divisor), valid while done is high
// One quotient bit per cycle, MSB first. The last bit is resolved
// combinationally in the done cycle so done lands exactly QW cycles after
// start. A zero divisor returns 2^(QW-1) (1.0 in the caller's scaling).
module softmax_div_seq #(
  parameter int DDW = 24,
  parameter int DSW = 23,
  parameter int QW  = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [DDW-1:0] dividend,
  input  logic [DSW-1:0] divisor,
  output logic           done,
  output logic [QW-1:0]  quotient
);

  localparam int RW = DDW + DSW + QW;

  logic          busy_q, busy_d;
  logic          dz_q, dz_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] dsr_q, dsr_d;
  logic [QW-1:0] q_q, q_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          ge;
  logic [QW-1:0] q_next;
  logic [RW-1:0] rem_next;

  always_comb begin
    ge       = (rem_q >= dsr_q);
    q_next   = (q_q << 1) | QW'(ge);
    rem_next = ge ? (rem_q - dsr_q) : rem_q;
  end

  always_comb begin
    busy_d = busy_q;
    dz_d   = dz_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    if (start) begin
      busy_d = 1'b1;
      dz_d   = (divisor == '0);
      rem_d  = RW'(dividend);
      dsr_d  = RW'(divisor) << (QW - 1);
      q_d    = '0;
      cnt_d  = 8'(QW);
    end else if (busy_q) begin
      rem_d = rem_next;
      dsr_d = dsr_q >> 1;
      q_d   = q_next;
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      dz_q   <= 1'b0;
      rem_q  <= '0;
      dsr_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      dz_q   <= dz_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    done     = busy_q && (cnt_q == 8'd1);
    quotient = dz_q ? {1'b1, {(QW-1){1'b0}}} : q_next;
  end

endmodule

// File: rtl/softmax_exp.sv
// Fixed-point exponential unit for non-positive arguments.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : request; operand num is taken when the unit is idle
//   num         : signed argument, expected <= 0
//   data_ready  : one-cycle pulse, exp_num valid in that cycle
//   exp_num     : exp(num) with FIXED_PNT fractional bits, range [0, 1.0]
// exp(x) = 2^(x*log2 e). The integer part of the exponent becomes a right
// shift applied one bit per cycle, so latency depends on the argument
// (1 cycle for exponent 0, up to FIXED_PNT+3 cycles for deep negatives).
// The fractional power is approximated linearly: 2^f ~= 1 + f.
module softmax_exp
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = FIXED_PNT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] num,
  output logic                         data_ready,
  output logic signed [DATA_WIDTH-1:0] exp_num
);

  localparam int PW        = DATA_WIDTH + 16;
  localparam int VW        = FIXED_PNT + 1;
  localparam int LOG2E_Q14 = 23637;          // log2(e) * 2^14
  localparam int SH_MAX    = FIXED_PNT + 2;  // value is already 0 past this

  logic          busy_q, busy_d;
  logic [VW-1:0] val_q, val_d;
  logic [7:0]    cnt_q, cnt_d;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] t;
  logic signed [PW-1:0] neg_n;
  logic [7:0]           shift;

  always_comb begin
    prod  = PW'(num) * PW'(LOG2E_Q14);
    t     = prod >>> 14;
    neg_n = -(t >>> FIXED_PNT);
    if (neg_n < 0) begin
      shift = 8'd0;
    end else if (neg_n > PW'(SH_MAX)) begin
      shift = 8'(SH_MAX);
    end else begin
      shift = neg_n[7:0];
    end
  end

  always_comb begin
    busy_d = busy_q;
    val_d  = val_q;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      if (enable) begin
        busy_d = 1'b1;
        val_d  = {1'b1, t[FIXED_PNT-1:0]};
        cnt_d  = shift;
      end
    end else if (cnt_q == 8'd0) begin
      busy_d = 1'b0;
    end else begin
      val_d = val_q >> 1;
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      val_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      val_q  <= val_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    data_ready = busy_q && (cnt_q == 8'd0);
    exp_num    = DATA_WIDTH'(val_q);
  end

endmodule

// File: rtl/softmax_stable.sv
// Numerically stable softmax over a latched vector of signed fixed-point values.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request pulse, honoured only in IDLE; vec_in captured then
//   vec_in     : input vector
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle pulse, vec_out valid
//   vec_out    : result, held until the next accepted start
//   dbg_state  : current controller state
// Handshake: start is a request with no acknowledge other than busy rising the
// next cycle; starts seen outside IDLE (including the DONE cycle) are dropped.
// done is a single-cycle completion strobe; there is no back-pressure.
// Flow: capture -> running max -> exp(x - max) into buf while summing ->
// one exact division per element into vec_out.
module softmax_stable
  import softmax_pkg::*;
#(
  parameter int VEC_SIZE   = 107,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = FIXED_PNT_DEF,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(VEC_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] vec_in  [VEC_SIZE],
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] vec_out [VEC_SIZE],
  output state_e                       dbg_state
);

  localparam int IW  = $clog2(VEC_SIZE);
  localparam int QWL = FIXED_PNT + 1;
  localparam int DDW = DATA_WIDTH + FIXED_PNT;
  localparam logic [IW-1:0] LAST = IW'(VEC_SIZE - 1);

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [SUM_WIDTH-1:0]         sum_q, sum_d;
  logic                         exp_enable_q, exp_enable_d;
  logic                         div_wait_q, div_wait_d;
  logic signed [DATA_WIDTH-1:0] buf_q [VEC_SIZE];
  logic signed [DATA_WIDTH-1:0] buf_d [VEC_SIZE];
  logic signed [DATA_WIDTH-1:0] vec_out_q [VEC_SIZE];
  logic signed [DATA_WIDTH-1:0] vec_out_d [VEC_SIZE];

  logic signed [DATA_WIDTH-1:0] cur;
  logic signed [DATA_WIDTH-1:0] exp_arg;
  logic                         exp_ready;
  logic signed [DATA_WIDTH-1:0] exp_val;
  logic                         div_start;
  logic                         div_done;
  logic [QWL-1:0]               div_quot;
  logic [DDW-1:0]               div_dividend;
  logic                         is_last;

  always_comb begin
    cur          = buf_q[idx_q];
    is_last      = (idx_q == LAST);
    // x - max never exceeds 0; saturation only matters at the negative end.
    exp_arg      = DATA_WIDTH'(sat_sub(32'(cur), 32'(max_q), DATA_WIDTH));
    // In DIV buf holds exp values in [0, 1.0], so the sign bit is clear.
    div_dividend = {cur, {FIXED_PNT{1'b0}}};
  end

  softmax_exp #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIXED_PNT  (FIXED_PNT)
  ) u_exp (
    .clk        (clk),
    .rst        (rst),
    .enable     (exp_enable_q),
    .num        (exp_arg),
    .data_ready (exp_ready),
    .exp_num    (exp_val)
  );

  softmax_div_seq #(
    .DDW      (DDW),
    .DSW      (SUM_WIDTH),
    .QW       (QWL)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (sum_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      max_q        <= '0;
      sum_q        <= '0;
      exp_enable_q <= 1'b0;
      div_wait_q   <= 1'b0;
      buf_q        <= '{default: '0};
      vec_out_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      max_q        <= max_d;
      sum_q        <= sum_d;
      exp_enable_q <= exp_enable_d;
      div_wait_q   <= div_wait_d;
      buf_q        <= buf_d;
      vec_out_q    <= vec_out_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: state_d = MAX;
      MAX:     if (is_last) state_d = EXP;
      EXP:     if (exp_ready && is_last) state_d = DIV;
      DIV:     if (div_wait_q && div_done && is_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates per state.
  always_comb begin
    idx_d        = idx_q;
    max_d        = max_q;
    sum_d        = sum_q;
    exp_enable_d = exp_enable_q;
    div_wait_d   = div_wait_q;
    buf_d        = buf_q;
    vec_out_d    = vec_out_q;
    case (state_q)
      IDLE: begin
        if (start) buf_d = vec_in;
      end
      CAPTURE: begin
        max_d = buf_q[0];
        idx_d = IW'(1);
      end
      MAX: begin
        // Strict compare: on ties the earlier element stays the max.
        if (cur > max_q) max_d = cur;
        if (is_last) begin
          idx_d        = '0;
          sum_d        = '0;
          exp_enable_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      EXP: begin
        if (exp_ready) begin
          buf_d[idx_q] = exp_val;
          sum_d        = sum_q + SUM_WIDTH'($unsigned(exp_val));
          // Dropping enable for a cycle lets the unit go idle before it
          // samples the next element's argument.
          exp_enable_d = 1'b0;
          idx_d        = is_last ? '0 : idx_q + IW'(1);
        end else begin
          exp_enable_d = 1'b1;
        end
      end
      DIV: begin
        if (!div_wait_q) begin
          div_wait_d = 1'b1;
        end else if (div_done) begin
          vec_out_d[idx_q] = DATA_WIDTH'(div_quot);
          div_wait_d       = 1'b0;
          idx_d            = is_last ? '0 : idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy      = (state_q == CAPTURE) || (state_q == MAX) ||
                (state_q == EXP) || (state_q == DIV);
    done      = (state_q == DONE);
    div_start = (state_q == DIV) && !div_wait_q;
    dbg_state = state_q;
    vec_out   = vec_out_q;
  end

endmodule

// File: tb/tb_softmax_stable.sv
module tb_softmax_stable;
  import softmax_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start4, busy4, done4;
  logic signed [15:0] vin4  [4];
  logic signed [15:0] vout4 [4];
  state_e             st4;

  logic               start107, busy107, done107;
  logic signed [15:0] vin107  [107];
  logic signed [15:0] vout107 [107];
  state_e             st107;

  softmax_stable #(.VEC_SIZE(4), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .vec_in(vin4),
    .busy(busy4), .done(done4), .vec_out(vout4), .dbg_state(st4)
  );

  softmax_stable #(.VEC_SIZE(107), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut107 (
    .clk(clk), .rst(rst), .start(start107), .vec_in(vin107),
    .busy(busy107), .done(done107), .vec_out(vout107), .dbg_state(st107)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_vec4(input int v [4]);
    for (int i = 0; i < 4; i++) vin4[i] = 16'(v[i]);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // Waits (bounded) for done4; counts cycles where busy4 was low before done.
  task automatic wait_done4(output int lat, output bit got, output int busy_gaps);
    lat = 0;
    got = 1'b0;
    busy_gaps = 0;
    while (!got && lat < 2000) begin
      if (done4) begin
        got = 1'b1;
      end else begin
        if (!busy4) busy_gaps++;
        tick();
        lat++;
      end
    end
  endtask

  // ---------------- golden model ----------------
  function automatic int exp_model(input int d);
    int t, n, f, k;
    t = (d * 23637) >>> 14;
    n = t >>> 8;
    f = t & 255;
    k = -n;
    if (k > 10) k = 10;
    return (256 + f) >> k;
  endfunction

  function automatic int sat16(input int x);
    if (x < -32768) return -32768;
    if (x > 32767) return 32767;
    return x;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b0;
    start107 = 1'b0;
    for (int i = 0; i < 4; i++) vin4[i] = 16'sd0;
    for (int i = 0; i < 107; i++) vin107[i] = 16'sd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy4, done4);
    end
    checks++;
    if (st4 !== IDLE || st107 !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d expected %0d", st4, st107, IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vout4[i] !== 16'sd0) begin
        errors++;
        $display("FAIL reset_vec_out[%0d] got %0d expected 0", i, vout4[i]);
      end
    end
  endtask

  // Full run of one 4-element vector with handshake and result checks.
  task automatic test_vector4(input string name, input int v [4], input int e [4]);
    int lat;
    bit got;
    int gaps;
    start_vec4(v);
    wait_done4(lat, got, gaps);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout no done after %0d cycles", name, lat);
      return;
    end
    checks++;
    if (gaps != 0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy low_cycles=%0d busy_at_done=%b expected 0 0", name, gaps, busy4);
    end
    checks++;
    if (lat < 40 || lat > 120) begin
      errors++;
      $display("FAIL %s_latency got %0d expected within 40..120", name, lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vout4[i] !== 16'(e[i])) begin
        errors++;
        $display("FAIL %s_vec_out[%0d] got %0d expected %0d", name, i, vout4[i], e[i]);
      end
    end
    tick();
    checks++;
    if (done4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width done still %b one cycle later, expected 0", name, done4);
    end
  endtask

  task automatic test_all_zero();
    test_vector4("all_zero", '{0, 0, 0, 0}, '{64, 64, 64, 64});
  endtask

  task automatic test_shift_invariance();
    test_vector4("shift_100", '{100, 100, 100, 100}, '{64, 64, 64, 64});
  endtask

  // e = exp(-1024/256) = 4, S = 256 + 3*4 = 268: 65536/268 = 244, 1024/268 = 3.
  task automatic test_one_hot();
    test_vector4("one_hot", '{1024, 0, 0, 0}, '{244, 3, 3, 3});
    checks++;
    if (!(vout4[0] > 16'sd240)) begin
      errors++;
      $display("FAIL one_hot_dominant got %0d expected > 240", vout4[0]);
    end
  endtask

  // -32768 - 32767 saturates to -32768; all non-max exps round to 0, S = 256.
  task automatic test_saturation();
    test_vector4("saturation", '{32767, -32768, 0, 0}, '{256, 0, 0, 0});
  endtask

  task automatic test_ignored_starts();
    int cyc;
    int dones;
    bit got;
    start_vec4('{0, 0, 0, 0});
    for (int i = 0; i < 4; i++) vin4[i] = (i == 0) ? 16'sd1024 : 16'sd0;
    cyc = 0;
    dones = 0;
    got = 1'b0;
    while (!got && cyc < 2000) begin
      if (done4) begin
        got = 1'b1;
      end else begin
        start4 = (cyc % 7 == 3);
        tick();
        cyc++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ignored_timeout no done after %0d cycles", cyc);
      start4 = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vout4[i] !== 16'sd64) begin
        errors++;
        $display("FAIL ignored_vec_out[%0d] got %0d expected 64", i, vout4[i]);
      end
    end
    // Start held through the DONE cycle must be dropped.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b0 || st4 !== IDLE) begin
      errors++;
      $display("FAIL done_cycle_start busy=%b state=%0d expected 0 %0d", busy4, st4, IDLE);
    end
    // Now in IDLE: this start is honoured and runs the one-hot vector.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL idle_start busy=%b expected 1", busy4);
    end
    cyc = 0;
    while (cyc < 200) begin
      if (done4) dones++;
      tick();
      cyc++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL idle_start_done_count got %0d expected 1", dones);
    end
    checks++;
    if (vout4[0] !== 16'sd244 || vout4[3] !== 16'sd3) begin
      errors++;
      $display("FAIL idle_start_result got %0d,%0d expected 244,3", vout4[0], vout4[3]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int dones;
    start_vec4('{1024, 0, 0, 0});
    cyc = 0;
    while (st4 !== EXP && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (st4 !== EXP) begin
      errors++;
      $display("FAIL reset_mid_reach_exp state=%0d expected %0d", st4, EXP);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (st4 !== IDLE || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state state=%0d busy=%b done=%b expected %0d 0 0",
               st4, busy4, done4, IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vout4[i] !== 16'sd0) begin
        errors++;
        $display("FAIL reset_mid_vec_out[%0d] got %0d expected 0", i, vout4[i]);
      end
    end
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      if (done4) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d done pulses expected 0", dones);
    end
    test_vector4("after_reset", '{0, 0, 0, 0}, '{64, 64, 64, 64});
  endtask

  task automatic test_random107();
    int x [107];
    int e [107];
    int exp_q [$];
    int mx, s, cyc, bad;
    bit got;
    for (int i = 0; i < 107; i++) begin
      x[i] = int'($urandom_range(0, 2000)) - 1500;
      vin107[i] = 16'(x[i]);
    end
    mx = x[0];
    for (int i = 1; i < 107; i++) if (x[i] > mx) mx = x[i];
    s = 0;
    for (int i = 0; i < 107; i++) begin
      e[i] = exp_model(sat16(x[i] - mx));
      s += e[i];
    end
    for (int i = 0; i < 107; i++) exp_q.push_back((e[i] * 256) / s);
    start107 = 1'b1;
    tick();
    start107 = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8000) begin
      if (done107) got = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL random107_timeout no done after %0d cycles", cyc);
      return;
    end
    bad = 0;
    for (int i = 0; i < 107; i++) begin
      int exp_v;
      exp_v = exp_q.pop_front();
      checks++;
      if (vout107[i] !== 16'(exp_v)) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL random107_vec_out[%0d] got %0d expected %0d", i, vout107[i], exp_v);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_all_zero();
    test_shift_invariance();
    test_one_hot();
    test_saturation();
    test_ignored_starts();
    test_reset_mid();
    test_random107();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
